// File: rtl/usb_pkg.sv
// usb_pkg: state encoding, endpoint sizes and bank index width shared by the USB IN path
package usb_pkg;
    localparam int USB_EP_MAX_PKT = 64;
    localparam int BANK_W = 1;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT_BANK = 3'd1;
    localparam logic [2:0] S_POP = 3'd2;
    localparam logic [2:0] S_LO = 3'd3;
    localparam logic [2:0] S_HI = 3'd4;
    localparam logic [2:0] S_ARM = 3'd5;
    typedef enum logic [2:0] {
        IDLE = S_IDLE,
        WAIT_BANK = S_WAIT_BANK,
        POP = S_POP,
        LO = S_LO,
        HI = S_HI,
        ARM = S_ARM
    } state_t;
endpackage

// File: rtl/usb_in_streamer.sv
// usb_in_streamer: drains the 16-bit SDRAM read FIFO into a double-banked USB IN endpoint buffer
// Optional: define FLUSH_TIMEOUT_EN to arm a partial packet after TIMEOUT cycles without FIFO data.
module usb_in_streamer
    import usb_pkg::*;
#(
    parameter int PKT_BYTES = USB_EP_MAX_PKT,
    parameter int TIMEOUT = 4800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        flush,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    input  logic [15:0] fifo_data,
    output logic        buf_we,
    output logic [6:0]  buf_addr,
    output logic [7:0]  buf_data,
    output logic        arm_valid,
    input  logic        arm_ready,
    output logic        arm_bank,
    output logic [6:0]  arm_len,
    input  logic        bank_release,
    input  logic        bank_release_idx,
    output logic        active
);
    localparam logic [6:0] PKT_LEN = 7'(PKT_BYTES);

    if (PKT_BYTES < 2 || PKT_BYTES > USB_EP_MAX_PKT || (PKT_BYTES & (PKT_BYTES - 1)) != 0 || TIMEOUT < 4) begin : g_bad_cfg
        $error("usb_in_streamer: unsupported PKT_BYTES or TIMEOUT");
    end

    state_t state;
    logic [BANK_W-1:0] cur_bank;
    logic [1:0] busy;
    logic [6:0] count;
    logic [7:0] word_hi;
    logic flush_pend;
    logic accept;
    logic tmo;
    logic go_arm;

    assign accept = (state == ARM) && arm_valid && arm_ready;
    assign go_arm = (flush || flush_pend || tmo) && count != 7'd0;

`ifdef FLUSH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;

    // Cycles since the last pop; frozen whenever the FIFO still holds data
    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE || accept)
            timer <= '0;
        else if (state == POP)
            timer <= TW'(1);
        else if (state == LO || state == HI || (state == WAIT_BANK && count != 7'd0 && fifo_empty))
            timer <= timer + TW'(1);
    end

    assign tmo = fifo_empty && timer >= TW'(TIMEOUT - 1);
`else
    assign tmo = 1'b0;
`endif

    // Endpoint bank mirror: accept marks a bank busy, release clears it and wins a same-cycle tie
    always_ff @(posedge clk) begin
        if (!rst_n)
            busy <= '0;
        else
            for (int i = 0; i < 2; i++)
                busy[i] <= !(bank_release && bank_release_idx == 1'(i)) && (busy[i] || (accept && cur_bank == 1'(i)));
    end

    // Sequencer: one word per POP/LO/HI pass, arming on a full packet, flush or timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cur_bank <= '0;
            count <= '0;
            word_hi <= '0;
            flush_pend <= 1'b0;
            fifo_rd <= 1'b0;
            buf_we <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            arm_valid <= 1'b0;
            arm_bank <= 1'b0;
            arm_len <= '0;
            active <= 1'b0;
        end else begin
            fifo_rd <= 1'b0;
            buf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_BANK;
                        active <= 1'b1;
                    end
                end
                WAIT_BANK: begin
                    flush_pend <= 1'b0;
                    if (!enable) begin
                        state <= IDLE;
                        active <= 1'b0;
                        count <= '0;
                    end else if (go_arm) begin
                        state <= ARM;
                        arm_valid <= 1'b1;
                        arm_bank <= cur_bank;
                        arm_len <= count;
                    end else if (!busy[cur_bank] && !fifo_empty) begin
                        state <= POP;
                        fifo_rd <= 1'b1;
                    end
                end
                POP: begin
                    flush_pend <= flush_pend || flush;
                    state <= LO;
                end
                LO: begin
                    flush_pend <= flush_pend || flush;
                    word_hi <= fifo_data[15:8];
                    buf_we <= 1'b1;
                    buf_addr <= {cur_bank, count[5:0]};
                    buf_data <= fifo_data[7:0];
                    state <= HI;
                end
                HI: begin
                    flush_pend <= flush_pend || flush;
                    buf_we <= 1'b1;
                    buf_addr <= {cur_bank, count[5:0] + 6'd1};
                    buf_data <= word_hi;
                    if (!enable) begin
                        state <= IDLE;
                        active <= 1'b0;
                        count <= '0;
                        flush_pend <= 1'b0;
                    end else if (count + 7'd2 == PKT_LEN) begin
                        state <= ARM;
                        count <= PKT_LEN;
                        arm_valid <= 1'b1;
                        arm_bank <= cur_bank;
                        arm_len <= PKT_LEN;
                    end else begin
                        state <= WAIT_BANK;
                        count <= count + 7'd2;
                    end
                end
                ARM: begin
                    if (arm_ready) begin
                        arm_valid <= 1'b0;
                        cur_bank <= ~cur_bank;
                        count <= '0;
                        flush_pend <= 1'b0;
                        state <= enable ? WAIT_BANK : IDLE;
                        active <= enable;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
